usb_ep_in_sched: RTL and testbench

USB_EP_IN_SCHED -- requirements
Module: usb_ep_in_sched

---
 rtl/usb_ep_in_sched.sv | 145 ++++++++++++++
 tb/tb_usb_ep_in_sched.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_ep_in_sched.sv
// IN-endpoint TX scheduler: locks one endpoint per packet onto the shared byte path.
// Define USB_EP_IN_SCHED_RR_EN for round-robin arbitration; otherwise lowest index wins.
module usb_ep_in_sched #(
  parameter int unsigned N_EP_IN       = 2,
  parameter int unsigned MAX_PKT_BYTES = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic [N_EP_IN-1:0]   i_inEp_req,
  input  logic [N_EP_IN*8-1:0] i_inEp_data,
  input  logic [N_EP_IN-1:0]   i_inEp_last,
  output logic [N_EP_IN-1:0]   o_inEp_grant,
  output logic [N_EP_IN-1:0]   o_inEp_accept,
  input  logic                 i_tx_ready,
  output logic                 o_tx_valid,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_last,
  output logic                 o_tx_abort
);

  localparam int unsigned SelW = (N_EP_IN > 1) ? $clog2(N_EP_IN) : 1;
  localparam int unsigned CntW = $clog2(MAX_PKT_BYTES);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_PKT_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StXfer, StAbort} state_e;

  state_e              state_q, state_d;
  logic [SelW-1:0]     sel_q, sel_d, winner;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [N_EP_IN-1:0]  grant_q, grant_d;
  logic                sel_req, sel_last, fire;
  logic [7:0]          sel_data;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= StIdle;
      sel_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

`ifdef USB_EP_IN_SCHED_RR_EN
  localparam logic [SelW-1:0] SelMax = SelW'(N_EP_IN - 1);

  logic [SelW-1:0] ptr_q, sel_next;
  logic            pkt_done, found;

  assign sel_next = (sel_q == SelMax) ? '0 : sel_q + SelW'(1);
  assign pkt_done = (state_q == StXfer) && (!sel_req || (fire && o_tx_last));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr_q <= '0;
    end else if (pkt_done) begin
      ptr_q <= sel_next;
    end
  end

  // First pass covers indices at or above ptr, second pass wraps to the bottom.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int j = 0; j < N_EP_IN; j++) begin
      if (!found && i_inEp_req[j] && (SelW'(j) >= ptr_q)) begin
        winner = SelW'(j);
        found  = 1'b1;
      end
    end
    for (int j = 0; j < N_EP_IN; j++) begin
      if (!found && i_inEp_req[j]) begin
        winner = SelW'(j);
        found  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int j = N_EP_IN - 1; j >= 0; j--) begin
      if (i_inEp_req[j]) winner = SelW'(j);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (|i_inEp_req) begin
          state_d = StXfer;
          sel_d   = winner;
          cnt_d   = '0;
          for (int j = 0; j < N_EP_IN; j++) grant_d[j] = (SelW'(j) == winner);
        end
      end
      StXfer: begin
        if (!sel_req) begin
          state_d = StAbort;
          grant_d = '0;
          cnt_d   = '0;
        end else if (fire) begin
          if (o_tx_last) begin
            state_d = StIdle;
            grant_d = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StAbort: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sel_req  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int j = 0; j < N_EP_IN; j++) begin
      if (SelW'(j) == sel_q) begin
        sel_req  = i_inEp_req[j];
        sel_last = i_inEp_last[j];
        sel_data = i_inEp_data[j*8 +: 8];
      end
    end
    o_inEp_grant  = grant_q;
    o_tx_valid    = (state_q == StXfer) && sel_req;
    o_tx_data     = (state_q == StXfer) ? sel_data : '0;
    o_tx_last     = o_tx_valid && (sel_last || (cnt_q == CntMax));
    fire          = o_tx_valid && i_tx_ready;
    o_inEp_accept = fire ? grant_q : '0;
    o_tx_abort    = (state_q == StAbort);
  end

endmodule

// File: tb/tb_usb_ep_in_sched.sv
// Self-checking bench for usb_ep_in_sched (N_EP_IN=2, MAX_PKT_BYTES=4): directed scenarios
// plus randomized endpoint traffic against a packet-level reference model.
module tb_usb_ep_in_sched;

  localparam int N   = 2;
  localparam int MAX = 4;
`ifdef USB_EP_IN_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic           clk   = 1'b0;
  logic           rstn  = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N-1:0]   last  = '0;
  logic [N*8-1:0] data  = '0;
  logic           ready = 1'b0;
  logic [N-1:0]   grant, accept;
  logic           valid, tlast, abort;
  logic [7:0]     tdata;

  int n_tests = 0;
  int n_fail  = 0;

  usb_ep_in_sched #(
    .N_EP_IN       (N),
    .MAX_PKT_BYTES (MAX)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_inEp_req    (req),
    .i_inEp_data   (data),
    .i_inEp_last   (last),
    .o_inEp_grant  (grant),
    .o_inEp_accept (accept),
    .i_tx_ready    (ready),
    .o_tx_valid    (valid),
    .o_tx_data     (tdata),
    .o_tx_last     (tlast),
    .o_tx_abort    (abort)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn  = 1'b0;
    req   = '0;
    last  = '0;
    data  = '0;
    ready = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn  = 1'b0;
    req   = 2'b11;
    last  = 2'b11;
    ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({grant, accept, valid, tlast, abort, tdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {grant, accept, valid, tlast, abort, tdata});
    end
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_rr();
    apply_reset();
    req   = 2'b11;
    data  = {8'hB0, 8'hA0};
    ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({grant, valid} !== 3'b000) begin
      n_fail++; $display("FAIL rr_idle: got %b want 000", {grant, valid});
    end
    for (int b = 0; b < 3; b++) begin
      tick();
      data[7:0] = 8'hA0 + 8'(b);
      last      = (b == 2) ? 2'b01 : 2'b00;
      @(negedge clk);
      n_tests++;
      if ({grant, accept, valid, tlast, tdata} !== {2'b01, 2'b01, 1'b1, 1'(b == 2), 8'hA0 + 8'(b)})
      begin
        n_fail++;
        $display("FAIL rr_ep0_byte%0d: got %h want %h", b, {grant, accept, valid, tlast, tdata},
                 {2'b01, 2'b01, 1'b1, 1'(b == 2), 8'hA0 + 8'(b)});
      end
    end
    tick();
    last = 2'b00;
    @(negedge clk);
    n_tests++;
    if ({grant, valid} !== 3'b000) begin
      n_fail++; $display("FAIL rr_gap: got %b want 000", {grant, valid});
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({grant, tdata} !== (RR ? {2'b10, 8'hB0} : {2'b01, 8'hA2})) begin
      n_fail++;
      $display("FAIL rr_second: got %h want %h", {grant, tdata},
               RR ? {2'b10, 8'hB0} : {2'b01, 8'hA2});
    end
  endtask

  task automatic test_ready_toggle();
    logic [7:0] exp_d[4] = '{8'hA1, 8'hA1, 8'hA2, 8'hA2};
    apply_reset();
    req       = 2'b01;
    data[7:0] = 8'hA1;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      tick();
      ready     = (c % 2 == 1);
      data[7:0] = exp_d[c];
      last      = (c == 3) ? 2'b01 : 2'b00;
      @(negedge clk);
      n_tests++;
      if ({grant, accept, valid, tlast, tdata} !==
          {2'b01, (c % 2 == 1) ? 2'b01 : 2'b00, 1'b1, 1'(c == 3), exp_d[c]}) begin
        n_fail++;
        $display("FAIL toggle_c%0d: got %h want %h", c, {grant, accept, valid, tlast, tdata},
                 {2'b01, (c % 2 == 1) ? 2'b01 : 2'b00, 1'b1, 1'(c == 3), exp_d[c]});
      end
    end
    tick();
    req  = 2'b00;
    last = 2'b00;
    @(negedge clk);
    n_tests++;
    if ({grant, valid, abort} !== 4'b0000) begin
      n_fail++; $display("FAIL toggle_end: got %b want 0000", {grant, valid, abort});
    end
  endtask

  task automatic test_abort();
    apply_reset();
    req   = 2'b10;
    ready = 1'b1;
    data  = 16'hC000;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      tick();
      data[15:8] = 8'hC0 + 8'(b);
      @(negedge clk);
      n_tests++;
      if ({grant, accept, valid, tdata} !== {2'b10, 2'b10, 1'b1, 8'hC0 + 8'(b)}) begin
        n_fail++;
        $display("FAIL abort_byte%0d: got %h want %h", b, {grant, accept, valid, tdata},
                 {2'b10, 2'b10, 1'b1, 8'hC0 + 8'(b)});
      end
    end
    tick();
    req = 2'b01;
    @(negedge clk);
    n_tests++;
    if ({grant, accept, valid, abort} !== 6'b10_00_0_0) begin
      n_fail++; $display("FAIL abort_drop: got %b want 100000", {grant, accept, valid, abort});
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({grant, valid, abort} !== 4'b00_0_1) begin
      n_fail++; $display("FAIL abort_pulse: got %b want 0001", {grant, valid, abort});
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({grant, valid, abort} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_after: got %b want 0000", {grant, valid, abort});
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (grant !== 2'b01) begin
      n_fail++; $display("FAIL abort_next_grant: got %b want 01", grant);
    end
  endtask

  task automatic test_forced_last();
    apply_reset();
    req   = 2'b01;
    ready = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      tick();
      @(negedge clk);
      n_tests++;
      if ({grant, accept, valid, tlast} !== {2'b01, 2'b01, 1'b1, 1'(b == 3)}) begin
        n_fail++;
        $display("FAIL forced_byte%0d: got %b want %b", b, {grant, accept, valid, tlast},
                 {2'b01, 2'b01, 1'b1, 1'(b == 3)});
      end
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({grant, valid} !== 3'b000) begin
      n_fail++; $display("FAIL forced_idle: got %b want 000", {grant, valid});
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({grant, tlast} !== 3'b010) begin
      n_fail++; $display("FAIL forced_restart: got %b want 010", {grant, tlast});
    end
  endtask

  task automatic test_priority();
    apply_reset();
    req   = 2'b11;
    last  = 2'b11;
    ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      n_tests++;
      if (grant !== 2'b00) begin
        n_fail++; $display("FAIL prio_idle%0d: got %b want 00", p, grant);
      end
      tick();
      @(negedge clk);
      n_tests++;
      if ({grant, tlast} !== {(RR && (p % 2 == 1)) ? 2'b10 : 2'b01, 1'b1}) begin
        n_fail++;
        $display("FAIL prio_pkt%0d: got %b want %b", p, {grant, tlast},
                 {(RR && (p % 2 == 1)) ? 2'b10 : 2'b01, 1'b1});
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req   = 2'b01;
    last  = 2'b01;
    ready = 1'b1;
    @(negedge clk);
    tick();
    tick();
    req  = 2'b11;
    last = 2'b00;
    @(negedge clk);
    tick();
    tick();
    @(negedge clk);
    n_tests++;
    if ({grant, valid} !== {RR ? 2'b10 : 2'b01, 1'b1}) begin
      n_fail++;
      $display("FAIL rstmid_byte2: got %b want %b", {grant, valid}, {RR ? 2'b10 : 2'b01, 1'b1});
    end
    #2;
    rstn = 1'b0;
    #1;
    n_tests++;
    if ({grant, accept, valid, tlast, abort, tdata} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: got %h want 0", {grant, accept, valid, tlast, abort, tdata});
    end
    tick();
    tick();
    rstn = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({grant, abort} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_noabort: got %b want 000", {grant, abort});
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (grant !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_restart: got %b want 01", grant);
    end
  endtask

  // Model tracks the packet owner, bytes sent in the packet and the rotation start.
  task automatic test_random();
    int         rem[N];
    logic [7:0] dv[N];
    int         owner, sent, start, win;
    bit         ab_pend;
    logic [N-1:0] e_grant, e_acc;
    logic       e_valid, e_last;
    logic [7:0] e_data;
    apply_reset();
    owner = -1; sent = 0; start = 0; ab_pend = 1'b0;
    for (int j = 0; j < N; j++) begin rem[j] = 0; dv[j] = '0; end
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int j = 0; j < N; j++) begin
        if (rem[j] == 0 && $urandom_range(0, 2) == 0) begin
          rem[j] = $urandom_range(1, 6);
          dv[j]  = 8'($urandom);
        end else if (rem[j] > 0 && $urandom_range(0, 19) == 0) begin
          rem[j] = 0;
        end
        req[j]         = (rem[j] > 0);
        last[j]        = (rem[j] == 1);
        data[j*8 +: 8] = dv[j];
      end
      ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      e_grant = '0; e_valid = 1'b0; e_last = 1'b0; e_acc = '0; e_data = '0;
      if (owner >= 0) begin
        e_grant = N'(1) << owner;
        e_valid = req[owner];
        e_data  = data[owner*8 +: 8];
        e_last  = e_valid && (last[owner] || sent == MAX - 1);
        e_acc   = (e_valid && ready) ? e_grant : '0;
      end
      n_tests++;
      if ({grant, accept, valid, tlast, abort} !== {e_grant, e_acc, e_valid, e_last, ab_pend}) begin
        n_fail++;
        $display("FAIL rand_c%0d: got g%b a%b v%b l%b ab%b want g%b a%b v%b l%b ab%b", cyc,
                 grant, accept, valid, tlast, abort, e_grant, e_acc, e_valid, e_last, ab_pend);
      end
      if (e_valid) begin
        n_tests++;
        if (tdata !== e_data) begin
          n_fail++; $display("FAIL rand_data_c%0d: got %h want %h", cyc, tdata, e_data);
        end
      end
      if (ab_pend) begin
        ab_pend = 1'b0;
      end else if (owner < 0) begin
        win = -1;
        for (int k = 0; k < N; k++) begin
          if (RR) begin
            if (win < 0 && req[(start + k) % N]) win = (start + k) % N;
          end else begin
            if (win < 0 && req[k]) win = k;
          end
        end
        owner = win;
        sent  = 0;
      end else if (!e_valid) begin
        ab_pend = 1'b1;
        start   = (owner + 1) % N;
        owner   = -1;
      end else if (ready) begin
        rem[owner]--;
        dv[owner]++;
        if (e_last) begin
          start = (owner + 1) % N;
          owner = -1;
        end else begin
          sent++;
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_rr();
    test_ready_toggle();
    test_abort();
    test_forced_last();
    test_priority();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
